mbox_arb: RTL
=============

MBOX_ARB -- requirements
Module: mbox_arb

Interface
REQ-001 The block SHALL have one clock, wb_clk_i, and an asynchronous active-low reset, wb_rst_n_i.
REQ-002 Parameter WB_DW, default 32: requester word width; only 32 is supported.
REQ-003 Parameter WOU_DW, default 8: mailbox byte width; only 8 is supported.
REQ-004 wb_clk_i  in  1  system clock; all logic is rising-edge.
REQ-005 wb_rst_n_i  in  1  asynchronous reset, active-low.
REQ-006 req0_vld_i  in  1  requester 0 has a word to send.
REQ-007 req0_dat_i  in  WB_DW  requester 0 word, sent least-significant byte first.
REQ-008 req0_len_i  in  2  requester 0 byte count minus 1 (0 = 1 byte, 3 = 4 bytes).
REQ-009 req0_rdy_o  out  1  one-cycle accept pulse for requester 0.
REQ-010 req1_vld_i, req1_dat_i, req1_len_i, req1_rdy_o: same as REQ-006 to REQ-009, for requester 1.
REQ-011 mbox_wr_o  out  1  mailbox byte write strobe.
REQ-012 mbox_do_o  out  WOU_DW  mailbox byte data.
REQ-013 mbox_full_i  in  1  mailbox full; no write is allowed while it is high.
REQ-014 busy_o  out  1  high while state is SEND.
REQ-015 owner_o  out  1  index of the requester that owns the current or last transfer.
REQ-016 word_cnt_o  out  16  count of completed words; wraps from 0xFFFF to 0.

Function
REQ-017 FSM states SHALL be IDLE and SEND; there are no other states.
REQ-018 In IDLE with at least one vld high:
- Pick a winner per REQ-019.
- Pulse the winner's rdy_o for exactly one cycle.
- Latch the winner's dat and len into the shift buffer and remaining-byte counter.
- Set owner_o and go to SEND.
REQ-019 Arbitration SHALL be round-robin:
- If only one vld is high, that requester wins.
- If both are high, the requester not granted last wins.
- After reset, requester 0 is treated as granted last, so requester 1 wins the first tie.
REQ-020 rdy_o SHALL never be high in SEND, and never for a requester whose vld_i is low.
REQ-021 A requester MAY deassert vld_i before its rdy_o pulse; nothing is latched for it.
REQ-022 In SEND:
- mbox_wr_o = ~mbox_full_i.
- mbox_do_o = buffer[7:0].
- On each cycle with mbox_full_i low, shift the buffer right by 8 and decrement the remaining count.
REQ-023 In SEND, a cycle with mbox_full_i high SHALL hold the buffer, the count and the state; no byte is lost or duplicated.
REQ-024 When the last byte is written (remaining = 0 and mbox_full_i low):
- Go to IDLE.
- Increment word_cnt_o.
- Update the round-robin pointer.
REQ-025 Latency: a word accepted in cycle t SHALL produce its first mbox_wr_o at t+1 at the earliest; an unstalled N-byte word occupies N+1 cycles, accept cycle included.
REQ-026 In IDLE, mbox_wr_o SHALL be 0 and mbox_do_o SHALL be 0.
REQ-027 mbox_full_i SHALL NOT block acceptance in IDLE; a stall applies only in SEND.

Reset
REQ-028 Reset SHALL be asynchronous on wb_rst_n_i low and SHALL set:
- state = IDLE; buffer = 0; remaining count = 0; round-robin pointer = requester 0.
- All rdy_o = 0; mbox_wr_o = 0; mbox_do_o = 0; busy_o = 0; owner_o = 0; word_cnt_o = 0.
REQ-029 Reset asserted during SEND SHALL abort the word immediately, with no further mailbox writes; on release the block SHALL be in IDLE.

Configuration
REQ-030 Macro MBOX_ARB_FIXED_PRIO_EN selects the arbitration policy:
- Defined: fixed priority; requester 0 always wins a tie, and the round-robin pointer is not implemented.
- Not defined: round-robin per REQ-019.
All other behaviour SHALL be identical in both builds.

Verification
REQ-031 Single word, no stall: req0 dat=0x44332211, len=3 -> rdy0 pulse; mbox bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; word_cnt_o=1.
REQ-032 Tie: both vld held high, len=0, dat0=0xAA, dat1=0xBB -> byte order BB, AA, BB, AA (round-robin build); AA, AA, AA (fixed-priority build).
REQ-033 Backpressure: req1 len=1, dat=0xCCDD, mbox_full_i high for 3 cycles after accept -> no mbox_wr_o during the stall, then DD, CC; busy_o stays high throughout.
REQ-034 Reset during SEND: wb_rst_n_i low after the 2nd of 4 bytes -> no further mbox_wr_o; all outputs 0 immediately; IDLE after release.
REQ-035 Counter wrap: preload 65535 words of len=0 -> word_cnt_o reads 0 after word 65536.

Source files
------------

// File: rtl/mbox_arb_if.sv
// rtl/mbox_arb_if.sv - requester and mailbox signal bundle for mbox_arb
interface mbox_arb_if #(
  parameter int WB_DW  = 32,
  parameter int WOU_DW = 8
);
  logic              req0_vld_i;
  logic [WB_DW-1:0]  req0_dat_i;
  logic [1:0]        req0_len_i;
  logic              req0_rdy_o;
  logic              req1_vld_i;
  logic [WB_DW-1:0]  req1_dat_i;
  logic [1:0]        req1_len_i;
  logic              req1_rdy_o;
  logic              mbox_wr_o;
  logic [WOU_DW-1:0] mbox_do_o;
  logic              mbox_full_i;
  logic              busy_o;
  logic              owner_o;
  logic [15:0]       word_cnt_o;

  modport slave (
    input  req0_vld_i, req0_dat_i, req0_len_i,
    input  req1_vld_i, req1_dat_i, req1_len_i,
    input  mbox_full_i,
    output req0_rdy_o, req1_rdy_o,
    output mbox_wr_o, mbox_do_o, busy_o, owner_o, word_cnt_o
  );

  modport master (
    output req0_vld_i, req0_dat_i, req0_len_i,
    output req1_vld_i, req1_dat_i, req1_len_i,
    output mbox_full_i,
    input  req0_rdy_o, req1_rdy_o,
    input  mbox_wr_o, mbox_do_o, busy_o, owner_o, word_cnt_o
  );
endinterface

// File: rtl/mbox_arb.sv
// rtl/mbox_arb.sv - two-requester word-to-byte mailbox arbiter
// MBOX_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties) instead of round-robin.
module mbox_arb #(
  parameter int WB_DW  = 32,
  parameter int WOU_DW = 8
) (
  input logic       wb_clk_i,
  input logic       wb_rst_n_i,
  mbox_arb_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WB_DW-1:0]  buf_q, buf_d;
  logic [1:0]        rem_q, rem_d;
  logic              owner_q, owner_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              any_vld, winner;
  logic              rdy0, rdy1, wr;
  logic [WOU_DW-1:0] dout;

  assign any_vld = bus.req0_vld_i | bus.req1_vld_i;

`ifdef MBOX_ARB_FIXED_PRIO_EN
  always_comb winner = ~bus.req0_vld_i;
`else
  // rr_last_q holds the requester that completed most recently; it loses the next tie.
  logic rr_last_q, rr_last_d;
  always_comb begin
    if (bus.req0_vld_i && bus.req1_vld_i) winner = ~rr_last_q;
    else                                  winner = ~bus.req0_vld_i;
  end
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rem_d      = rem_q;
    owner_d    = owner_q;
    word_cnt_d = word_cnt_q;
`ifndef MBOX_ARB_FIXED_PRIO_EN
    rr_last_d  = rr_last_q;
`endif
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    wr         = 1'b0;
    dout       = '0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          rdy0    = ~winner;
          rdy1    = winner;
          buf_d   = winner ? bus.req1_dat_i : bus.req0_dat_i;
          rem_d   = winner ? bus.req1_len_i : bus.req0_len_i;
          owner_d = winner;
          state_d = SEND;
        end
      end
      SEND: begin
        wr   = ~bus.mbox_full_i;
        dout = buf_q[WOU_DW-1:0];
        if (!bus.mbox_full_i) begin
          buf_d = buf_q >> WOU_DW;
          if (rem_q == 2'd0) begin
            state_d    = IDLE;
            word_cnt_d = word_cnt_q + 16'd1;
`ifndef MBOX_ARB_FIXED_PRIO_EN
            rr_last_d  = owner_q;
`endif
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      rem_q      <= '0;
      owner_q    <= 1'b0;
      word_cnt_q <= '0;
`ifndef MBOX_ARB_FIXED_PRIO_EN
      rr_last_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      rem_q      <= rem_d;
      owner_q    <= owner_d;
      word_cnt_q <= word_cnt_d;
`ifndef MBOX_ARB_FIXED_PRIO_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  // Accept pulses are combinational, so gate them off while reset is held.
  assign bus.req0_rdy_o = rdy0 & wb_rst_n_i;
  assign bus.req1_rdy_o = rdy1 & wb_rst_n_i;
  assign bus.mbox_wr_o  = wr;
  assign bus.mbox_do_o  = dout;
  assign bus.busy_o     = (state_q == SEND);
  assign bus.owner_o    = owner_q;
  assign bus.word_cnt_o = word_cnt_q;
endmodule
